// File: rtl/tactile_scanner_if.sv
// Signal bundle between the tactile scanner, its ADC and the frame BRAM write port.
// adc_start/adc_valid: one-cycle request, later one-cycle response; no backpressure, one conversion in flight.
interface tactile_scanner_if #(
  parameter int SW_WIRE_CNT = 16,
  parameter int RD_WIRE_CNT = 16
);
  localparam int SW_W   = $clog2(SW_WIRE_CNT);
  localparam int RD_W   = $clog2(RD_WIRE_CNT);
  localparam int ADDR_W = $clog2(SW_WIRE_CNT * RD_WIRE_CNT);

  logic              start;
  logic              continuous;
  logic [11:0]       adc_data;
  logic              adc_valid;
  logic              adc_start;
  logic [SW_W-1:0]   sw_sel;
  logic [RD_W-1:0]   rd_sel;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [11:0]       bram_data;
  logic              busy;
  logic              frame_done;

  modport master (
    input  start, continuous, adc_data, adc_valid,
    output adc_start, sw_sel, rd_sel, bram_we, bram_addr, bram_data, busy, frame_done
  );

  modport slave (
    output start, continuous, adc_data, adc_valid,
    input  adc_start, sw_sel, rd_sel, bram_we, bram_addr, bram_data, busy, frame_done
  );
endinterface

// File: rtl/tactile_scanner.sv
// Frame acquisition front end: steps switch/read selects over every cell, settles,
// converts once per cell and writes the 12-bit sample to the frame BRAM at sw*RD_WIRE_CNT+rd.
module tactile_scanner #(
  parameter int SW_WIRE_CNT   = 16,
  parameter int RD_WIRE_CNT   = 16,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  tactile_scanner_if.master bus,
  output logic [2:0]        dbg_state_o
);
  localparam int SW_W   = $clog2(SW_WIRE_CNT);
  localparam int RD_W   = $clog2(RD_WIRE_CNT);
  localparam int ADDR_W = $clog2(SW_WIRE_CNT * RD_WIRE_CNT);
  localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [SW_W-1:0]   SW_LAST   = SW_W'(SW_WIRE_CNT - 1);
  localparam logic [RD_W-1:0]   RD_LAST   = RD_W'(RD_WIRE_CNT - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] RD_STRIDE = ADDR_W'(RD_WIRE_CNT);

  // IDLE encodes as 0 so the debug state reads all-zero out of reset.
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETTLE  = 3'd1;
  localparam logic [2:0] S_CONVERT = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_WRITE   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [SW_W-1:0]   sw_q, sw_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              adc_start_q, adc_start_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [11:0]       data_q, data_d;
  logic              done_q, done_d;

  logic              last_cell;
  logic [ADDR_W-1:0] cell_addr;

  assign last_cell = (sw_q == SW_LAST) && (rd_q == RD_LAST);
  assign cell_addr = ADDR_W'(sw_q) * RD_STRIDE + ADDR_W'(rd_q);

  always_comb begin
    state_d     = state_q;
    sw_d        = sw_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    adc_start_d = 1'b0;
    we_d        = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sw_d    = '0;
          rd_d    = '0;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          adc_start_d = 1'b1;
          state_d     = S_CONVERT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CONVERT: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Strobe and write controls are registered so they line up with the WRITE state.
        if (bus.adc_valid) begin
          data_d  = bus.adc_data;
          addr_d  = cell_addr;
          we_d    = 1'b1;
          done_d  = last_cell;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        cnt_d = '0;
        if (last_cell) begin
          // Selects stay parked on the last cell when the frame ends in IDLE.
          if (bus.continuous) begin
            sw_d    = '0;
            rd_d    = '0;
            state_d = S_SETTLE;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          if (rd_q == RD_LAST) begin
            rd_d = '0;
            sw_d = sw_q + 1'b1;
          end else begin
            rd_d = rd_q + 1'b1;
          end
          state_d = S_SETTLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sw_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      adc_start_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sw_q        <= sw_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      adc_start_q <= adc_start_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      done_q      <= done_d;
    end
  end

  assign bus.adc_start  = adc_start_q;
  assign bus.sw_sel     = sw_q;
  assign bus.rd_sel     = rd_q;
  assign bus.bram_we    = we_q;
  assign bus.bram_addr  = addr_q;
  assign bus.bram_data  = data_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.frame_done = done_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_tactile_scanner.sv
// Bench for tactile_scanner: default 16x16 instance plus a 3x5 instance, driven by
// behavioural ADC models with an expected-write scoreboard.
module tb_tactile_scanner;
  localparam int SW  = 16;
  localparam int RD  = 16;
  localparam int SET = 8;
  localparam int NC  = SW * RD;
  localparam int AW  = $clog2(NC);
  localparam int SW3 = 3;
  localparam int RD3 = 5;
  localparam int NC3 = SW3 * RD3;
  localparam int TMO = 20000;

  typedef struct {
    int lat_min;
    int lat_max;
    bit stray;
    bit addr_data;
    int fixed_cycles;
    int exp_writes;
  } frame_vec_t;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;
  logic [2:0] dbg_state3;

  int n_vec = 0;
  int n_err = 0;

  // Model state for the 16x16 instance
  logic [AW-1:0] exp_addr_q[$];
  logic [11:0]   exp_data_q[$];
  int            cell_k = 0;
  int            exp_cycles = 0;
  int            n_writes = 0;
  int            n_done = 0;
  int            lat_min = 1;
  int            lat_max = 1;
  bit            stray_en = 1'b0;
  bit            addr_data = 1'b0;
  logic [11:0]   last_d = '0;

  // Model state for the 3x5 instance
  logic [11:0]   exp3_q[$];
  int            k3 = 0;
  int            n3_writes = 0;

  tactile_scanner_if #(.SW_WIRE_CNT(SW), .RD_WIRE_CNT(RD)) bus ();
  tactile_scanner_if #(.SW_WIRE_CNT(SW3), .RD_WIRE_CNT(RD3)) bus3 ();

  tactile_scanner #(.SW_WIRE_CNT(SW), .RD_WIRE_CNT(RD), .SETTLE_CYCLES(SET)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  tactile_scanner #(.SW_WIRE_CNT(SW3), .RD_WIRE_CNT(RD3), .SETTLE_CYCLES(SET)) u_dut3 (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus3),
    .dbg_state_o (dbg_state3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_sw_sel"},     bus.sw_sel,     0);
    check({tag, "_rd_sel"},     bus.rd_sel,     0);
    check({tag, "_bram_addr"},  bus.bram_addr,  0);
    check({tag, "_bram_data"},  bus.bram_data,  0);
    check({tag, "_adc_start"},  bus.adc_start,  0);
    check({tag, "_bram_we"},    bus.bram_we,    0);
    check({tag, "_busy"},       bus.busy,       0);
    check({tag, "_frame_done"}, bus.frame_done, 0);
    check({tag, "_state"},      dbg_state,      0);
  endtask

  task automatic start_and_wait(output int cycles);
    exp_cycles = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    cycles = 1;
    while (!bus.frame_done && cycles < TMO) begin
      @(negedge clk);
      cycles++;
    end
    check("frame_done_seen", bus.frame_done, 1);
  endtask

  // ADC model for the 16x16 instance: answers each request after lat cycles,
  // records the write the scan should produce for the cell it is on.
  initial begin : adc_model
    logic [11:0]     d;
    int              lat;
    bit              aborted;
    bit              stable;
    logic [3:0]      sw0;
    logic [3:0]      rd0;
    bus.adc_valid = 1'b0;
    bus.adc_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.adc_start) begin
        lat = $urandom_range(lat_max, lat_min);
        d   = addr_data ? 12'(cell_k) : 12'($urandom);
        check("sel_sw", bus.sw_sel, cell_k / RD);
        check("sel_rd", bus.rd_sel, cell_k % RD);
        exp_addr_q.push_back(AW'(cell_k));
        exp_data_q.push_back(d);
        exp_cycles += SET + 2 + lat;
        cell_k = (cell_k + 1) % NC;
        sw0 = bus.sw_sel;
        rd0 = bus.rd_sel;
        stable  = 1'b1;
        aborted = 1'b0;
        for (int i = 0; i < lat; i++) begin
          @(negedge clk);
          if (rst) aborted = 1'b1;
          if (bus.sw_sel !== sw0 || bus.rd_sel !== rd0) stable = 1'b0;
        end
        if (!aborted) begin
          check("sel_stable_wait", stable, 1);
          bus.adc_valid = 1'b1;
          bus.adc_data  = d;
          last_d = d;
          @(negedge clk);
          bus.adc_valid = 1'b0;
          bus.adc_data  = ~d;
          if (stray_en) begin
            @(negedge clk);
            @(negedge clk);
            bus.adc_valid = 1'b1;
            @(negedge clk);
            bus.adc_valid = 1'b0;
            check("stray_data_hold", bus.bram_data, last_d);
          end
        end
      end
    end
  end

  initial begin : monitor
    logic [AW-1:0] ea;
    logic [11:0]   ed;
    forever begin
      @(negedge clk);
      if (!rst && bus.bram_we) begin
        n_writes++;
        check("write_pending", exp_addr_q.size() > 0, 1);
        if (exp_addr_q.size() > 0) begin
          ea = exp_addr_q.pop_front();
          ed = exp_data_q.pop_front();
          check("wr_addr", bus.bram_addr, ea);
          check("wr_data", bus.bram_data, ed);
          check("wr_frame_done", bus.frame_done, ea == AW'(NC - 1));
        end
      end
      if (!rst && bus.frame_done) begin
        n_done++;
        check("done_with_we", bus.bram_we, 1);
      end
    end
  end

  initial begin : adc_model3
    logic [11:0] d;
    bus3.adc_valid = 1'b0;
    bus3.adc_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus3.adc_start) begin
        d = 12'($urandom);
        check("sel3_sw", bus3.sw_sel, k3 / RD3);
        check("sel3_rd", bus3.rd_sel, k3 % RD3);
        exp3_q.push_back(d);
        k3 = (k3 + 1) % NC3;
        @(negedge clk);
        bus3.adc_valid = 1'b1;
        bus3.adc_data  = d;
        @(negedge clk);
        bus3.adc_valid = 1'b0;
        bus3.adc_data  = ~d;
      end
    end
  end

  initial begin : monitor3
    logic [11:0] ed;
    forever begin
      @(negedge clk);
      if (!rst && bus3.bram_we) begin
        check("wr3_addr", bus3.bram_addr, n3_writes % NC3);
        check("wr3_in_range", bus3.bram_addr < NC3, 1);
        check("wr3_frame_done", bus3.frame_done, (n3_writes % NC3) == NC3 - 1);
        check("wr3_pending", exp3_q.size() > 0, 1);
        if (exp3_q.size() > 0) begin
          ed = exp3_q.pop_front();
          check("wr3_data", bus3.bram_data, ed);
        end
        n3_writes++;
      end
    end
  end

  initial begin : main
    frame_vec_t vecs[4];
    int cyc;
    int w0;
    int d0;

    vecs[0] = '{lat_min: 1,  lat_max: 1,  stray: 1'b0, addr_data: 1'b1, fixed_cycles: 2816, exp_writes: 256};
    vecs[1] = '{lat_min: 10, lat_max: 10, stray: 1'b1, addr_data: 1'b0, fixed_cycles: 5120, exp_writes: 256};
    vecs[2] = '{lat_min: 1,  lat_max: 6,  stray: 1'b0, addr_data: 1'b0, fixed_cycles: -1,   exp_writes: 256};
    vecs[3] = '{lat_min: 2,  lat_max: 4,  stray: 1'b1, addr_data: 1'b0, fixed_cycles: -1,   exp_writes: 256};

    bus.start       = 1'b0;
    bus.continuous  = 1'b0;
    bus3.start      = 1'b0;
    bus3.continuous = 1'b0;
    rst = 1'b1;

    // Start pulse while held in reset
    @(negedge clk);
    bus.start  = 1'b1;
    bus3.start = 1'b1;
    @(negedge clk);
    check_idle("in_reset");
    check("in_reset_busy3", bus3.busy, 0);
    check("in_reset_state3", dbg_state3, 0);
    bus.start  = 1'b0;
    bus3.start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_busy", bus.busy, 0);
    check("idle_adc_start", bus.adc_start, 0);
    check("idle_busy3", bus3.busy, 0);

    for (int v = 0; v < 4; v++) begin
      lat_min   = vecs[v].lat_min;
      lat_max   = vecs[v].lat_max;
      stray_en  = vecs[v].stray;
      addr_data = vecs[v].addr_data;
      w0 = n_writes;
      d0 = n_done;
      start_and_wait(cyc);
      check("frame_cycles_model", cyc, exp_cycles);
      if (vecs[v].fixed_cycles > 0) check("frame_cycles_fixed", cyc, vecs[v].fixed_cycles);
      @(negedge clk);
      check("busy_drop", bus.busy, 0);
      repeat (8) @(negedge clk);
      check("frame_writes", n_writes - w0, vecs[v].exp_writes);
      check("frame_done_count", n_done - d0, 1);
      check("queue_drained", exp_addr_q.size(), 0);
    end

    // Continuous mode: two back-to-back frames, stray start pulses, continuous dropped mid frame 2
    lat_min = 1;
    lat_max = 3;
    stray_en = 1'b0;
    addr_data = 1'b0;
    bus.continuous = 1'b1;
    w0 = n_writes;
    d0 = n_done;
    start_and_wait(cyc);
    check("cont_f1_cycles", cyc, exp_cycles);
    exp_cycles = 0;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("cont_no_gap_busy", bus.busy, 1);
      if (bus.frame_done || cyc >= TMO) break;
      bus.start = ($urandom_range(0, 63) == 0);
      if (cyc == 700) bus.continuous = 1'b0;
    end
    bus.start = 1'b0;
    check("cont_f2_done", bus.frame_done, 1);
    check("cont_f2_cycles", cyc, exp_cycles);
    @(negedge clk);
    check("cont_end_idle", bus.busy, 0);
    repeat (4) @(negedge clk);
    check("cont_writes", n_writes - w0, 2 * NC);
    check("cont_done_count", n_done - d0, 2);

    // Reset during WAIT of cell 37, then a fresh frame from address 0
    lat_min = 10;
    lat_max = 10;
    w0 = n_writes;
    d0 = n_done;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (n_writes - w0 < 37 && cyc < TMO) begin
      @(negedge clk);
      cyc++;
    end
    while (!bus.adc_start && cyc < TMO) begin
      @(negedge clk);
      cyc++;
    end
    check("reached_cell37", n_writes - w0, 37);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_idle("rst_in_wait");
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (12) @(negedge clk);
    check("rst_no_done", n_done - d0, 0);
    check("rst_no_more_writes", n_writes - w0, 37);
    check("rst_stays_idle", bus.busy, 0);
    exp_addr_q.delete();
    exp_data_q.delete();
    cell_k = 0;
    lat_min = 1;
    lat_max = 1;
    w0 = n_writes;
    d0 = n_done;
    start_and_wait(cyc);
    check("restart_cycles", cyc, exp_cycles);
    @(negedge clk);
    check("restart_busy_drop", bus.busy, 0);
    check("restart_writes", n_writes - w0, NC);
    check("restart_done_count", n_done - d0, 1);

    // Non-power-of-two instance
    w0 = n3_writes;
    bus3.start = 1'b1;
    @(negedge clk);
    bus3.start = 1'b0;
    check("f3_busy_after_start", bus3.busy, 1);
    cyc = 1;
    while (!bus3.frame_done && cyc < TMO) begin
      @(negedge clk);
      cyc++;
    end
    check("f3_done", bus3.frame_done, 1);
    check("f3_cycles", cyc, NC3 * (SET + 3));
    @(negedge clk);
    check("f3_busy_drop", bus3.busy, 0);
    repeat (4) @(negedge clk);
    check("f3_writes", n3_writes - w0, NC3);
    check("f3_queue_drained", exp3_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tactile_scanner.md
# tactile_scanner

Frame acquisition front end for the tactile array. It steps the switch-wire and read-wire mux selects across every cell and waits a settle interval at each one. It then runs one ADC conversion per cell and writes the 12-bit sample into the frame BRAM at address sw*RD_WIRE_CNT + rd. It is the writer for the BRAM that the convolution datapath reads through `in_bram_addr`/`in_bram_data`.

## Interface
- SW_WIRE_CNT, 16, number of driven switch wires (≥2)
- RD_WIRE_CNT, 16, number of read wires (≥2)
- SETTLE_CYCLES, 8, clocks the select lines are held before conversion starts (≥1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin one frame; sampled only in IDLE
- continuous  in  1  at end of frame, restart immediately instead of returning to IDLE
- adc_data  in  12  conversion result, valid when adc_valid=1
- adc_valid  in  1  one-cycle result strobe from ADC
- adc_start  out  1  one-cycle conversion request
- sw_sel  out  $clog2(SW_WIRE_CNT)  active switch wire index
- rd_sel  out  $clog2(RD_WIRE_CNT)  active read wire index
- bram_we  out  1  frame BRAM write enable
- bram_addr  out  $clog2(SW_WIRE_CNT*RD_WIRE_CNT)  write address
- bram_data  out  12  write data
- busy  out  1  high whenever state ≠ IDLE
- frame_done  out  1  one-cycle pulse on the final write of a frame

## Operation
- States: IDLE, SETTLE, CONVERT, WAIT, WRITE.
- IDLE:
  - On start=1, load sw=0, rd=0 and clear the settle counter.
  - Go to SETTLE.
- SETTLE:
  - The counter runs from 0 to SETTLE_CYCLES-1.
  - When the counter reaches SETTLE_CYCLES-1, go to CONVERT.
- CONVERT:
  - adc_start=1 for exactly this cycle.
  - Go to WAIT.
- WAIT:
  - Hold until adc_valid=1, then capture adc_data into bram_data and go to WRITE.
  - adc_valid in any other state is ignored; no data is captured.
  - No timeout: WAIT holds indefinitely.
- WRITE:
  - bram_we=1 and bram_addr=sw*RD_WIRE_CNT+rd, both registered.
  - Then advance the scan:
    - rd increments; at RD_WIRE_CNT-1 it wraps to 0 and sw increments.
    - Return to SETTLE with the counter cleared.
  - Last cell (sw=SW_WIRE_CNT-1, rd=RD_WIRE_CNT-1):
    - frame_done=1 in this WRITE cycle.
    - Next state is SETTLE at (0,0) if continuous=1 in this cycle, else IDLE.
- Scan order: rd is the inner loop, sw the outer loop. Addresses therefore increase monotonically 0..SW*RD-1.
- Non-power-of-two counts: wrap happens at CNT-1, never at the natural width overflow. Unused address codes are never driven with bram_we=1.
- start while busy=1 is ignored. Clearing continuous mid-frame takes effect only at the last WRITE.
- sw_sel/rd_sel change only on the WRITE→SETTLE transition or on the IDLE→SETTLE load. They are therefore stable throughout SETTLE, CONVERT and WAIT of a cell.

## Timing
- Reset values (async, immediate):
  - state=IDLE
  - sw_sel=0, rd_sel=0
  - bram_addr=0, bram_data=0
  - adc_start=0, bram_we=0, busy=0, frame_done=0
- Reset mid-frame: state returns to IDLE and outputs take reset values at once. A partially written frame is not completed and no frame_done is issued.
- start at edge N: busy=1 from cycle N+1 and SETTLE begins at N+1.
- Per cell:
  - SETTLE_CYCLES in SETTLE, then 1 in CONVERT.
  - Then W ≥ 1 in WAIT, where W=1 if adc_valid arrives in the first WAIT cycle.
  - Then 1 in WRITE.
  - Minimum per cell: SETTLE_CYCLES+3 clocks.
- bram_data is updated from adc_data on the adc_valid edge and held through WRITE.
- Frame time at minimum ADC latency: SW*RD*(SETTLE_CYCLES+3) clocks. With default parameters that is 2816 clocks.
- In continuous mode the gap between frames is zero extra cycles: the next SETTLE starts immediately after the final WRITE.

## Test plan
- Reset then idle: assert rst mid-stream -> all outputs 0 immediately; a start pulse while rst=1 has no effect.
- Single frame with default parameters and an ADC model that returns data=addr one cycle after adc_start:
  - 256 writes at addresses 0..255 with data equal to address.
  - frame_done pulses once, with the write to address 255.
  - busy deasserts the next cycle.
  - Total frame time 2816 clocks.
- Slow ADC: valid arrives 10 cycles after adc_start, and a stray adc_valid is injected during SETTLE -> stray strobe ignored; no extra write; selects stable during WAIT.
- Non-power-of-two, SW=3, RD=5:
  - Addresses 0..14 written once each.
  - rd_sel wraps 4→0 while sw_sel increments.
  - No write to address 15.
- Continuous mode held high for two frames -> second frame's first SETTLE begins the cycle after the write to address 255. start pulses during the frames are ignored. After continuous drops, the frame ends in IDLE.
- Reset asserted during WAIT of cell 37 -> IDLE at once. A new start begins at address 0.
